// File: rtl/movavg_ser_if.sv
// movavg_ser_if: input-word and result-word handshake bundle for movavg_ser.
// The master modport is the producer/consumer side; the slave modport is the engine.
interface movavg_ser_if #(
    parameter int WIDTH     = 64,
    parameter int TAPS_LOG2 = 2
) ();
    localparam int SUMW = WIDTH + TAPS_LOG2;

    logic [WIDTH-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic             avg;
    logic             flush;
    logic [SUMW-1:0]  dout;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output din, in_valid, avg, flush, out_ready,
        input  in_ready, dout, out_valid
    );

    modport slave (
        input  din, in_valid, avg, flush, out_ready,
        output in_ready, dout, out_valid
    );
endinterface

// File: rtl/movavg_ser.sv
// movavg_ser: bit-serial moving sum/average over the last 2**TAPS_LOG2 accepted words.
// One result bit per clock, LSB first, using a TAPS_LOG2-bit carry so the sum is exact.
module movavg_ser #(
    parameter int WIDTH     = 64,
    parameter int TAPS_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    movavg_ser_if.slave bus
);
    localparam int TAPS = 1 << TAPS_LOG2;
    localparam int SUMW = WIDTH + TAPS_LOG2;
    localparam int CNTW = $clog2(SUMW);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SUMW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hist_q [TAPS];
    logic [WIDTH-1:0]     hist_d [TAPS];
    logic [SUMW-1:0]      work_q [TAPS];
    logic [SUMW-1:0]      work_d [TAPS];
    logic [TAPS_LOG2-1:0] carry_q, carry_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [SUMW-2:0]      res_q;
    logic [SUMW-1:0]      res_d;
    logic [SUMW-1:0]      dout_q, dout_d;
    logic                 out_valid_q, out_valid_d;
    logic                 avg_q, avg_d;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 flush_en_s;
    logic                 last_s;
    logic [TAPS_LOG2:0]   col_s;

    assign accept_s   = bus.in_valid && in_ready_s;
    assign flush_en_s = bus.flush && (state_q != ST_BUSY);
    assign last_s     = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_d = last_s ? ST_DONE : ST_BUSY;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = bus.in_valid ? ST_BUSY : ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: in_ready never looks at in_valid
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s = 1'b1;
            ST_DONE: in_ready_s = bus.out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // History, working shifters and the serial column adder
    always_comb begin
        hist_d  = hist_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        col_s   = {1'b0, carry_q};
        for (int i = 0; i < TAPS; i++) begin
            col_s = col_s + {{TAPS_LOG2{1'b0}}, work_q[i][0]};
        end
        res_d = {col_s[0], res_q};
        if (accept_s) begin
            // A flush with the accept empties the window before din lands in it
            hist_d[0] = bus.din;
            for (int i = 1; i < TAPS; i++) begin
                hist_d[i] = flush_en_s ? {WIDTH{1'b0}} : hist_q[i-1];
            end
            for (int i = 0; i < TAPS; i++) begin
                work_d[i] = {{TAPS_LOG2{1'b0}}, hist_d[i]};
            end
            carry_d = {TAPS_LOG2{1'b0}};
            cnt_d   = {CNTW{1'b0}};
            avg_d   = bus.avg;
        end else if (state_q == ST_BUSY) begin
            for (int i = 0; i < TAPS; i++) begin
                work_d[i] = work_q[i] >> 1;
            end
            carry_d = col_s[TAPS_LOG2:1];
            cnt_d   = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else if (flush_en_s) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_d[i] = {WIDTH{1'b0}};
            end
        end else begin
            avg_d = avg_q;
        end
    end

    // Registered result and valid; the result is captured only on the final serial bit
    always_comb begin
        dout_d      = dout_q;
        out_valid_d = (state_d == ST_DONE);
        if (last_s) begin
            dout_d = avg_q ? {{TAPS_LOG2{1'b0}}, res_d[SUMW-1:TAPS_LOG2]} : res_d;
        end else begin
            dout_d = dout_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= {WIDTH{1'b0}};
                work_q[i] <= {SUMW{1'b0}};
            end
            carry_q     <= {TAPS_LOG2{1'b0}};
            cnt_q       <= {CNTW{1'b0}};
            res_q       <= {(SUMW-1){1'b0}};
            dout_q      <= {SUMW{1'b0}};
            out_valid_q <= 1'b0;
            avg_q       <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_q       <= (state_q == ST_BUSY) ? res_d[SUMW-1:1] : res_q;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            avg_q       <= avg_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.dout      = dout_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_movavg_ser.sv
// tb_movavg_ser: directed checks on an 8-bit/4-tap instance plus a randomized
// 64-bit/4-tap run against a behavioural window-sum model.
module tb_movavg_ser;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    movavg_ser_if #(.WIDTH(8),  .TAPS_LOG2(2)) s ();
    movavg_ser_if #(.WIDTH(64), .TAPS_LOG2(2)) b ();

    movavg_ser #(.WIDTH(8),  .TAPS_LOG2(2)) dut_s (.clk(clk), .reset(reset), .bus(s));
    movavg_ser #(.WIDTH(64), .TAPS_LOG2(2)) dut_b (.clk(clk), .reset(reset), .bus(b));

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        s.in_valid = 1'b0; s.flush = 1'b0; s.avg = 1'b0; s.din = 8'd0; s.out_ready = 1'b1;
        b.in_valid = 1'b0; b.flush = 1'b0; b.avg = 1'b0; b.din = 64'd0; b.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits from just after an accept edge; the latency count doubles as the timeout check
    task automatic wait_s(input logic [9:0] exp, input string tag);
        int n;
        n = 0;
        while (s.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        s.flush = 1'b0;
        chk({tag, "/lat"}, 72'(n), 72'd10);
        chk(tag, 72'(s.dout), 72'(exp));
    endtask

    task automatic feed_s(input logic [7:0] d, input logic a, input logic f, input logic fbusy,
                          input logic [9:0] exp, input string tag);
        int n;
        @(negedge clk);
        s.din = d; s.avg = a; s.flush = f; s.in_valid = 1'b1;
        n = 0;
        while (s.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1;
        s.in_valid = 1'b0;
        s.flush    = fbusy;
        wait_s(exp, tag);
    endtask

    task automatic feed_b(input logic [63:0] d, input logic a, input logic [65:0] exp, input string tag);
        int n;
        @(negedge clk);
        b.din = d; b.avg = a; b.in_valid = 1'b1;
        n = 0;
        while (b.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        n = 0;
        while (b.out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "/lat"}, 72'(n), 72'd66);
        chk(tag, 72'(b.dout), 72'(exp));
    endtask

    initial begin
        logic [63:0] h [4];
        logic [63:0] d;
        logic [63:0] leg;
        logic [65:0] e;
        logic        a;
        int          vcount;

        // Reset values
        do_reset();
        #1;
        chk("rst_in_ready", 72'(s.in_ready), 72'd1);
        chk("rst_out_valid", 72'(s.out_valid), 72'd0);
        chk("rst_dout", 72'(s.dout), 72'd0);

        // Sum mode stream
        feed_s(8'd10, 1'b0, 1'b0, 1'b0, 10'd10,  "sum1");
        feed_s(8'd20, 1'b0, 1'b0, 1'b0, 10'd30,  "sum2");
        feed_s(8'd30, 1'b0, 1'b0, 1'b0, 10'd60,  "sum3");
        feed_s(8'd40, 1'b0, 1'b0, 1'b0, 10'd100, "sum4");
        feed_s(8'd50, 1'b0, 1'b0, 1'b0, 10'd140, "sum5");

        // Average mode stream
        do_reset();
        feed_s(8'd10, 1'b1, 1'b0, 1'b0, 10'd2,  "avg1");
        feed_s(8'd20, 1'b1, 1'b0, 1'b0, 10'd7,  "avg2");
        feed_s(8'd30, 1'b1, 1'b0, 1'b0, 10'd15, "avg3");
        feed_s(8'd40, 1'b1, 1'b0, 1'b0, 10'd25, "avg4");
        feed_s(8'd50, 1'b1, 1'b0, 1'b0, 10'd35, "avg5");

        // Mode latched per word
        do_reset();
        feed_s(8'd10, 1'b0, 1'b0, 1'b0, 10'd10, "alt1");
        feed_s(8'd20, 1'b1, 1'b0, 1'b0, 10'd7,  "alt2");
        feed_s(8'd30, 1'b0, 1'b0, 1'b0, 10'd60, "alt3");
        feed_s(8'd40, 1'b1, 1'b0, 1'b0, 10'd25, "alt4");

        // Full-scale inputs use the extra output bits
        do_reset();
        feed_s(8'd255, 1'b0, 1'b0, 1'b0, 10'd255,  "ovf_s1");
        feed_s(8'd255, 1'b0, 1'b0, 1'b0, 10'd510,  "ovf_s2");
        feed_s(8'd255, 1'b0, 1'b0, 1'b0, 10'd765,  "ovf_s3");
        feed_s(8'd255, 1'b0, 1'b0, 1'b0, 10'd1020, "ovf_s4");
        do_reset();
        feed_s(8'd255, 1'b1, 1'b0, 1'b0, 10'd63,  "ovf_a1");
        feed_s(8'd255, 1'b1, 1'b0, 1'b0, 10'd127, "ovf_a2");
        feed_s(8'd255, 1'b1, 1'b0, 1'b0, 10'd191, "ovf_a3");
        feed_s(8'd255, 1'b1, 1'b0, 1'b0, 10'd255, "ovf_a4");

        // Backpressure, then release with a word waiting
        do_reset();
        s.out_ready = 1'b0;
        feed_s(8'd3, 1'b0, 1'b0, 1'b0, 10'd3, "bp_first");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_dout", 72'(s.dout), 72'd3);
            chk("bp_in_ready", 72'(s.in_ready), 72'd0);
            chk("bp_out_valid", 72'(s.out_valid), 72'd1);
        end
        @(negedge clk);
        s.out_ready = 1'b1; s.din = 8'd4; s.avg = 1'b0; s.in_valid = 1'b1;
        @(posedge clk); #1;
        s.in_valid = 1'b0;
        chk("bp_taken_valid", 72'(s.out_valid), 72'd0);
        chk("bp_taken_busy", 72'(s.in_ready), 72'd0);
        wait_s(10'd7, "bp_next");

        // Flush with accept, flush ignored in BUSY, flush while idle
        do_reset();
        feed_s(8'd10, 1'b0, 1'b0, 1'b0, 10'd10, "fl1");
        feed_s(8'd20, 1'b0, 1'b0, 1'b0, 10'd30, "fl2");
        feed_s(8'd30, 1'b0, 1'b0, 1'b0, 10'd60, "fl3");
        feed_s(8'd7,  1'b0, 1'b1, 1'b0, 10'd7,  "fl_acc");
        feed_s(8'd1,  1'b0, 1'b0, 1'b0, 10'd8,  "fl_after");
        feed_s(8'd2,  1'b0, 1'b0, 1'b1, 10'd10, "fl_busy");
        feed_s(8'd3,  1'b0, 1'b0, 1'b0, 10'd13, "fl_busy_kept");
        @(negedge clk); s.flush = 1'b1;
        @(negedge clk); s.flush = 1'b0;
        feed_s(8'd4,  1'b0, 1'b0, 1'b0, 10'd4,  "fl_idle");

        // Reset in the middle of a computation
        do_reset();
        feed_s(8'd10, 1'b0, 1'b0, 1'b0, 10'd10, "mid_pre");
        @(negedge clk);
        s.din = 8'd20; s.in_valid = 1'b1;
        @(posedge clk); #1;
        s.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_in_ready", 72'(s.in_ready), 72'd1);
        chk("mid_out_valid", 72'(s.out_valid), 72'd0);
        chk("mid_dout", 72'(s.dout), 72'd0);
        @(negedge clk);
        reset = 1'b1;
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (s.out_valid === 1'b1) vcount++;
        end
        chk("mid_no_partial", 72'(vcount), 72'd0);
        feed_s(8'd5, 1'b0, 1'b0, 1'b0, 10'd5, "mid_after");

        // Default widths against a window-sum model and the legacy 64-bit wrap
        do_reset();
        for (int i = 0; i < 4; i++) h[i] = 64'd0;
        for (int k = 0; k < 256; k++) begin
            d = {$urandom, $urandom};
            if (k < 4) d = 64'hFFFF_FFFF_FFFF_FFFF;
            a = 1'($urandom_range(0, 1));
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = d;
            e   = {2'b00, h[0]} + {2'b00, h[1]} + {2'b00, h[2]} + {2'b00, h[3]};
            leg = h[0] + h[1] + h[2] + h[3];
            feed_b(d, a, a ? (e >> 2) : e, "big");
            if (!a) chk("big_legacy", 72'(b.dout[63:0]), 72'(leg));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
